// File: rtl/gcd_dispatch.sv
// Job dispatcher for a sequential GCD core: queues operand pairs in a small FIFO,
// launches one job at a time and holds each result until the consumer acknowledges it.
module gcd_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             push,
  output logic             full,
  output logic             overflow,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             start_out,
  input  logic [WIDTH-1:0] gcd_in,
  input  logic             done_in,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [7:0]       jobs_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t               state;
  state_t               next_state;
  logic [2*WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 empty;
  logic                 do_pop;
  logic                 do_push;
  logic                 is_bypass;
  logic [WIDTH-1:0]     head_a;
  logic [WIDTH-1:0]     head_b;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign {head_a, head_b} = mem[rd_ptr];
  assign is_bypass = (head_a == '0) || (head_b == '0);
  assign do_pop    = (state == IDLE) && !empty && !res_valid;
  // A simultaneous pop frees the head slot, so a push at full still fits.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {a_in, b_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Jobs with a zero operand skip the core and go straight to HOLD.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (do_pop) begin
          next_state = is_bypass ? HOLD : RUN;
        end
      end
      RUN: begin
        if (done_in) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (res_valid && res_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_out = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      jobs_done <= '0;
    end else begin
      if (do_pop) begin
        a_out <= head_a;
        b_out <= head_b;
        if (is_bypass) begin
          res       <= (head_a == '0) ? head_b : head_a;
          res_valid <= 1'b1;
        end
      end
      if ((state == RUN) && done_in) begin
        res       <= gcd_in;
        res_valid <= 1'b1;
      end
      if ((state == HOLD) && res_valid && res_ack) begin
        res_valid <= 1'b0;
        jobs_done <= jobs_done + 8'd1;
      end
    end
  end

endmodule
